// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the frame buffer read-side scan-out logic.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int RD_LAT    = 1;
    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

    // A word closes its line when the following address starts a new one.
    function automatic logic is_eol(input int addr, input int line_len);
        return ((addr + 1) % line_len) == 0;
    endfunction

endpackage

// File: rtl/frame_buf_skid_fifo.sv
// Two-entry FIFO that absorbs memory read latency in front of the pixel stream.
module frame_buf_skid_fifo
    import frame_buf_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 empty,
    output logic                 full,
    output logic [BUF_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
    logic [WIDTH-1:0]     mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BUF_CNT_W-1:0] count_q, count_d;

    // The owner only pushes with room (or a same-cycle pop) and only pops when non-empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == BUF_CNT_W'(BUF_DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/frame_buf_rd_ctrl.sv
// Frame buffer scan-out: walks the memory read port and emits a valid/ready pixel stream.
// Define FRAME_BUF_RD_WRAP_EN for continuous scan; default is single-shot per start pulse.
module frame_buf_rd_ctrl
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 8,
    parameter int LINE_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_eol,
    output logic                  pix_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam int FIFO_W = DATA_WIDTH + 2;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [RD_LAT-1:0]     vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0]     eol_pipe_q, eol_pipe_d;
    logic [RD_LAT-1:0]     last_pipe_q, last_pipe_d;
    logic                  done_q, done_d;

    logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [BUF_CNT_W-1:0]  fifo_count;
    logic [FIFO_W-1:0]     fifo_head;
    logic                  credit_ok;

    assign pix_valid = !fifo_empty;
    assign {pix_eol, pix_last, pix_data} = fifo_head;
    assign fifo_pop  = pix_valid && pix_ready;
    assign fifo_push = vld_pipe_q[RD_LAT-1] && (!fifo_full || fifo_pop);

    // Reads still in the memory pipeline already own a buffer slot.
    assign credit_ok = (int'(fifo_count) + $countones(vld_pipe_q) - int'(fifo_pop)) < BUF_DEPTH;

    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        rd_en       = 1'b0;
        rd_addr     = last_addr_q;
        done_d      = fifo_pop && pix_last;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    rd_en       = 1'b1;
                    rd_addr     = cnt_q;
                    last_addr_d = cnt_q;
                    cnt_d       = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ADDR) begin
`ifdef FRAME_BUF_RD_WRAP_EN
                        cnt_d = '0;
`else
                        state_d = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && pix_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_pipe_d  = RD_LAT'({vld_pipe_q, rd_en});
        eol_pipe_d  = RD_LAT'({eol_pipe_q, rd_en && is_eol(int'(cnt_q), LINE_LEN)});
        last_pipe_d = RD_LAT'({last_pipe_q, rd_en && (cnt_q == LAST_ADDR)});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_addr_q <= '0;
            vld_pipe_q  <= '0;
            eol_pipe_q  <= '0;
            last_pipe_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            eol_pipe_q  <= eol_pipe_d;
            last_pipe_q <= last_pipe_d;
            done_q      <= done_d;
        end
    end

    frame_buf_skid_fifo #(
        .WIDTH(FIFO_W)
    ) u_skid_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data({eol_pipe_q[RD_LAT-1], last_pipe_q[RD_LAT-1], rd_data}),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_frame_buf_rd_ctrl.sv
// Directed bench for frame_buf_rd_ctrl: cycle table for the basic frame plus scoreboarded sequences.
module tb_frame_buf_rd_ctrl;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int FRAME_LEN  = 8;
    localparam int LINE_LEN   = 4;

    typedef struct packed {
        logic        start;
        logic        ready;
        logic        busy;
        logic        rdEn;
        logic [2:0]  rdAddr;
        logic        valid;
        logic [15:0] data;
        logic        eol;
        logic        last;
        logic        done;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rdEn;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] rdData = '0;
    logic [DATA_WIDTH-1:0] pixData;
    logic                  pixValid;
    logic                  pixReady;
    logic                  pixEol;
    logic                  pixLast;

    logic [DATA_WIDTH-1:0] mem [FRAME_LEN];
    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    // One-cycle-latency memory model behind the read port.
    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddr];
    end

    frame_buf_rd_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .LINE_LEN  (LINE_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .rd_data  (rdData),
        .pix_data (pixData),
        .pix_valid(pixValid),
        .pix_ready(pixReady),
        .pix_eol  (pixEol),
        .pix_last (pixLast)
    );

    task automatic checkBit(input string name, input logic actual, input logic expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
        end
    endtask

    task automatic checkWord(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic st, input logic rdy, input logic bsy, input logic re,
                                   input logic [2:0] ad, input logic v, input logic [15:0] d,
                                   input logic e, input logic l, input logic dn);
        vec_t r;
        r.start = st; r.ready = rdy; r.busy = bsy; r.rdEn = re; r.rdAddr = ad;
        r.valid = v; r.data = d; r.eol = e; r.last = l; r.done = dn;
        return r;
    endfunction

    function automatic logic readyFor(input int kind, input int c);
        case (kind)
            1:       return (c % 3) == 0;
            2:       return c >= 11;
            default: return 1'b1;
        endcase
    endfunction

    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        pixReady = v.ready;
    endtask

    task automatic checkOutput(input int row, input vec_t v);
        checkBit($sformatf("row%0d_busy", row), busy, v.busy);
        checkBit($sformatf("row%0d_rd_en", row), rdEn, v.rdEn);
        checkWord($sformatf("row%0d_rd_addr", row), 16'(rdAddr), 16'(v.rdAddr));
        checkBit($sformatf("row%0d_valid", row), pixValid, v.valid);
        checkBit($sformatf("row%0d_done", row), done, v.done);
        if (v.valid) begin
            checkWord($sformatf("row%0d_data", row), pixData, v.data);
            checkBit($sformatf("row%0d_eol", row), pixEol, v.eol);
            checkBit($sformatf("row%0d_last", row), pixLast, v.last);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkBit({tag, "_busy"}, busy, 1'b0);
        checkBit({tag, "_done"}, done, 1'b0);
        checkBit({tag, "_rd_en"}, rdEn, 1'b0);
        checkWord({tag, "_rd_addr"}, 16'(rdAddr), 16'h0);
        checkBit({tag, "_valid"}, pixValid, 1'b0);
        checkWord({tag, "_data"}, pixData, 16'h0);
        checkBit({tag, "_eol"}, pixEol, 1'b0);
        checkBit({tag, "_last"}, pixLast, 1'b0);
    endtask

    // Runs frames from a start pulse with a ready pattern, scoreboarding every transfer.
    task automatic runFrame(input int kind, input int rePulse, input int frames);
        int   total, c, xfer, doneCnt, held, rdCnt;
        logic inflight, prevLast, pop;
        total = frames * FRAME_LEN;
        c = 0; xfer = 0; doneCnt = 0; held = 0; rdCnt = 0;
        inflight = 1'b0; prevLast = 1'b0;
        while (doneCnt < frames && c < 400) begin
            start    = (c == 0) || (c == rePulse);
            pixReady = readyFor(kind, c);
            #1;
            pop = pixValid && pixReady;
            checkBit("valid_vs_held", pixValid, held != 0);
            if (held == 2 && !pop) checkBit("no_read_when_full", rdEn, 1'b0);
            if (kind == 0 && xfer > 0 && xfer < total) checkBit("no_gap", pixValid, 1'b1);
            if (kind == 2 && c >= 3 && c <= 10) begin
                checkBit("stall_valid", pixValid, 1'b1);
                checkWord("stall_data", pixData, 16'h0001);
            end
            if (kind == 2 && c <= 10 && rdEn) rdCnt++;
            if (kind == 2 && c == 10) checkInt("stall_reads", rdCnt, 2);
            if (done) begin
                doneCnt++;
                checkBit("done_after_last", prevLast, 1'b1);
            end
            if (pop) begin
                checkWord("pix_data", pixData, 16'((xfer % FRAME_LEN) + 1));
                checkBit("pix_eol", pixEol, (((xfer % FRAME_LEN) + 1) % LINE_LEN) == 0);
                checkBit("pix_last", pixLast, (xfer % FRAME_LEN) == FRAME_LEN - 1);
                xfer++;
            end
            prevLast = pop && pixLast;
            held     = held + int'(inflight) - int'(pop);
            inflight = rdEn;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        checkBit("frame_done_in_budget", doneCnt == frames, 1'b1);
        checkInt("xfer_count", xfer, total);
`ifdef FRAME_BUF_RD_WRAP_EN
        checkBit("busy_stays_high", busy, 1'b1);
`else
        checkBit("idle_after_done", busy, 1'b0);
`endif
    endtask

    initial begin
        vec_t vecs[13];
        int   xfer;
        int   extraDone;

        for (int i = 0; i < FRAME_LEN; i++) mem[i] = 16'(i + 1);

        //                 st    rdy   busy  rd_en addr  valid data     eol   last  done
        vecs[0]  = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        vecs[10] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 16'h0008, 1'b1, 1'b1, 1'b0);
        vecs[11] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        vecs[12] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        reset    = 1'b0;
        start    = 1'b0;
        pixReady = 1'b0;
        #1;
        checkZeros("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef FRAME_BUF_RD_WRAP_EN
        $display("[TB] continuous scan, three frames back to back");
        runFrame(0, -1, 3);
        reset = 1'b0;
        #1;
        checkZeros("wrap_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`else
        $display("[TB] single frame, ready held high");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i]);
            @(negedge clk);
        end
        start = 1'b0;

        $display("[TB] ready pattern 1,0,0 repeating");
        runFrame(1, -1, 1);

        $display("[TB] ready low for ten cycles after start");
        runFrame(2, -1, 1);

        $display("[TB] start re-pulsed while running");
        runFrame(0, 5, 1);
        extraDone = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (done || busy) extraDone++;
            @(negedge clk);
        end
        checkInt("no_second_frame", extraDone, 0);

        $display("[TB] reset after the third transfer");
        xfer = 0;
        for (int c = 0; c < 40 && xfer < 3; c++) begin
            start    = (c == 0);
            pixReady = 1'b1;
            #1;
            if (pixValid && pixReady) xfer++;
            @(negedge clk);
        end
        start = 1'b0;
        checkInt("pre_reset_xfers", xfer, 3);
        reset = 1'b0;
        #1;
        checkZeros("midframe_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        runFrame(0, -1, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/frame_buf_rd_ctrl.md
# frame_buf_rd_ctrl

Read-side scan-out controller for the frame buffer, sitting directly downstream of the dual-port data memory. It walks the memory's read port through a frame one word at a time and turns the fixed-latency read data into a valid/ready pixel stream with line and frame markers. A 2-entry output buffer absorbs the memory latency, so a stalled consumer never loses a word and an unstalled one gets one pixel per clock.

## Interface
- DATA_WIDTH, 16, pixel/memory word width
- ADDR_WIDTH, 3, memory address width
- FRAME_LEN, 8, words per frame; 2 ≤ FRAME_LEN ≤ 2**ADDR_WIDTH
- LINE_LEN, 4, words per line; FRAME_LEN is a multiple of LINE_LEN
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  one-cycle pulse, begins a frame from address 0
- busy  out  1  high from start acceptance until frame done
- done  out  1  one-cycle pulse after the last word is accepted downstream
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_WIDTH  memory read address
- rd_data  in  DATA_WIDTH  memory read data, valid the cycle after rd_en
- pix_data  out  DATA_WIDTH  stream data
- pix_valid  out  1  stream valid
- pix_ready  in  1  stream ready; transfer when valid && ready
- pix_eol  out  1  qualifies pix_data as the last word of a line
- pix_last  out  1  qualifies pix_data as the last word of the frame

## Operation
- FSM states IDLE, RUN, DRAIN.
- IDLE: start=1 → RUN, busy=1, read address counter=0. start while busy is ignored.
- RUN: issue a read (rd_en=1, rd_addr=counter) when occupancy + in-flight − pop-this-cycle < 2; counter increments per issue. On issuing address FRAME_LEN−1 → DRAIN.
- DRAIN: no reads issued. When the word tagged pix_last transfers → IDLE, busy=0, done pulses.
- In-flight read: rd_data is written into the buffer the cycle after rd_en, together with tags eol = ((addr+1) mod LINE_LEN == 0) and last = (addr == FRAME_LEN−1).
- Buffer: 2-entry FIFO. Head drives pix_data/pix_eol/pix_last. pix_valid = not empty. Data, eol and last hold stable while valid && !ready.
- Words are emitted in address order, with no duplication or loss under any pix_ready pattern.
- rd_addr holds its last value when rd_en=0.

## Timing
- Reset values: busy 0, done 0, rd_en 0, rd_addr 0, pix_valid 0, pix_data 0, pix_eol 0, pix_last 0, FSM IDLE, buffer empty.
- start is sampled at edge N. rd_en=1 for address 0 in the cycle after N. pix_valid rises 3 cycles after N.
- With pix_ready held at 1: one transfer per clock. done pulses the cycle after the final transfer. Total is FRAME_LEN+3 cycles from start to done.
- With pix_ready=0: at most 2 words are buffered and rd_en stays 0. Issue resumes in the same cycle as the pop that frees credit.
- Same-cycle push and pop: occupancy is unchanged and ordering is preserved.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, and any in-flight rd_data is discarded.

## Configuration
- FRAME_BUF_RD_WRAP_EN defined: continuous scan. After address FRAME_LEN−1, the counter returns to 0 and RUN continues without a new start. done still pulses on each pix_last transfer, busy stays 1, and the only exit is reset.
- Not defined: single-shot. The FSM returns to IDLE after each frame, as described under Operation.

## Structure
- Shared package frame_buf_pkg holds the state enum (IDLE/RUN/DRAIN), the read-latency constant RD_LAT=1, and the buffer depth constant 2.
- One sub-module: frame_buf_skid_fifo, a 2-entry FIFO of width DATA_WIDTH+2 with push/pop/empty/full/count.
- The top level holds the FSM, address counter, credit logic and tag generation.

## Test plan
- Memory preloaded with 0x0001..0x0008, default parameters, pix_ready=1, start pulse → pix_data 0x0001..0x0008 on 8 consecutive cycles starting 3 clocks after start; eol on words 4 and 8; last on word 8; done the next cycle.
- Same preload, pix_ready toggling 1,0,0,1,… → the same 8-word sequence with no loss or repeat; rd_en never asserted while 2 words are held.
- pix_ready=0 for 10 cycles after start → pix_valid=1 with pix_data=0x0001 stable throughout; exactly 2 reads issued.
- start re-pulsed during RUN → ignored, and the frame completes with a single done.
- reset driven to 0 after the 3rd transfer → all outputs 0 immediately; a new start rescans from 0x0001.
- FRAME_BUF_RD_WRAP_EN defined, pix_ready=1 → the sequence 0x0001..0x0008 repeats with no gap, and done pulses once per frame.
